// File: rtl/denorm_postproc.sv
// rtl/denorm_postproc.sv - restores original-scale samples from left-justified normalised samples
//
// Purpose: takes a normalised sample and its shift amount, shifts right by at
// most STEP bits per cycle, optionally rounds half-up on the last bit shifted
// out, saturates to DATA_WIDTH and presents the result over valid/ready.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in_valid     in   upstream sample valid
//   in_ready     out  block can accept a sample (IDLE only)
//   data_in      in   normalised sample, NORM_WIDTH bits
//   shift_in     in   right-shift amount, SHIFT_WIDTH bits
//   out_valid    out  data_out valid
//   out_ready    in   downstream accepts
//   data_out     out  restored sample, DATA_WIDTH bits
//   sample_count out  completed output handshakes, 16-bit wrapping
module denorm_postproc #(
  parameter int DATA_WIDTH  = 16,
  parameter int NORM_WIDTH  = DATA_WIDTH,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int STEP        = 4,
  parameter int ROUND       = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NORM_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [15:0]            sample_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  // The remaining-shift register can never exceed its own maximum, so a STEP
  // larger than that behaves identically to the clamped value and fits rem.
  localparam int REM_MAX = (1 << SHIFT_WIDTH) - 1;
  localparam int STEP_C  = (STEP < REM_MAX) ? STEP : REM_MAX;
  localparam logic [SHIFT_WIDTH-1:0] STEP_K = SHIFT_WIDTH'(STEP_C);
  localparam logic ROUND_EN = (ROUND != 0);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [NORM_WIDTH-1:0]  r_acc;
  logic [SHIFT_WIDTH-1:0] r_rem;
  logic                   r_rbit;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_data_out;
  logic [15:0]            r_sample_count;

  logic [SHIFT_WIDTH-1:0] w_k;
  logic [SHIFT_WIDTH-1:0] w_rem_next;
  logic [NORM_WIDTH-1:0]  w_pre;
  logic [NORM_WIDTH:0]    w_sum;
  logic                   w_ovf;
  logic [DATA_WIDTH-1:0]  w_result;
  logic                   w_in_ready;

  assign w_k        = (r_rem < STEP_K) ? r_rem : STEP_K;
  assign w_rem_next = r_rem - w_k;
  // Shift by k-1 first so bit 0 is the last bit to fall off; one more shift
  // completes the k-bit step. Only meaningful in SHIFT, where k >= 1.
  assign w_pre      = r_acc >> (w_k - 1'b1);

  assign w_sum    = {1'b0, r_acc} + {{NORM_WIDTH{1'b0}}, ROUND_EN & r_rbit};
  assign w_ovf    = |w_sum[NORM_WIDTH:DATA_WIDTH];
  assign w_result = w_ovf ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = (shift_in != '0) ? S_SHIFT : S_FIN;
        end
      end
      S_SHIFT: begin
        if (w_rem_next == '0) begin
          w_state_next = S_FIN;
        end
      end
      S_FIN: begin
        w_state_next = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_rem          <= '0;
      r_rbit         <= 1'b0;
      r_out_valid    <= 1'b0;
      r_data_out     <= '0;
      r_sample_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc  <= data_in;
            r_rem  <= shift_in;
            r_rbit <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_rbit <= w_pre[0];
          r_acc  <= w_pre >> 1;
          r_rem  <= w_rem_next;
        end
        S_FIN: begin
          r_data_out  <= w_result;
          r_out_valid <= 1'b1;
        end
        S_SEND: begin
          if (out_ready) begin
            r_out_valid    <= 1'b0;
            r_sample_count <= r_sample_count + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Gated by the raw reset so in_ready drops the instant reset asserts.
  assign in_ready     = w_in_ready & reset;
  assign out_valid    = r_out_valid;
  assign data_out     = r_data_out;
  assign sample_count = r_sample_count;

endmodule

// File: tb/tb_denorm_postproc.sv
// tb/tb_denorm_postproc.sv - self-checking bench for denorm_postproc
module tb_denorm_postproc;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] data_in;
  logic [3:0]  shift_in;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] data_out;
  logic [15:0] sample_count;

  logic        in_ready_t;
  logic        out_valid_t;
  logic [15:0] data_out_t;
  logic [15:0] sample_count_t;

  int n_pass;
  int n_total;
  int exp_count;

  denorm_postproc #(
    .DATA_WIDTH(16), .NORM_WIDTH(16), .SHIFT_WIDTH(4), .STEP(4), .ROUND(1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .shift_in(shift_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sample_count(sample_count)
  );

  denorm_postproc #(
    .DATA_WIDTH(16), .NORM_WIDTH(16), .SHIFT_WIDTH(4), .STEP(4), .ROUND(0)
  ) dut_t (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_t),
    .data_in(data_in), .shift_in(shift_in),
    .out_valid(out_valid_t), .out_ready(out_ready),
    .data_out(data_out_t), .sample_count(sample_count_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: the whole right shift at once; the rounding bit is bit s-1
  // of the original sample; saturate to 16 bits.
  function automatic int ref_out(input int d, input int s, input int rnd);
    int full;
    int rb;
    int sum;
    full = (s >= 32) ? 0 : (d >> s);
    rb   = (s == 0 || s > 32) ? 0 : ((d >> (s - 1)) & 1);
    sum  = full + ((rnd != 0) ? rb : 0);
    return (sum > 65535) ? 65535 : sum;
  endfunction

  task automatic run_sample(input logic [15:0] d, input logic [3:0] s, input int stall);
    int n;
    int exp1;
    int exp0;
    logic [15:0] held;
    exp1 = ref_out(int'(d), int'(s), 1);
    exp0 = ref_out(int'(d), int'(s), 0);
    @(negedge clk);
    data_in   = d;
    shift_in  = s;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", in_ready, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n + 1, 2 + (int'(s) + 3) / 4);
    chk("data_out_round", data_out, exp1);
    chk("data_out_trunc", data_out_t, exp0);
    held = data_out;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      data_in  = ~d;
      @(posedge clk);
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_data_out", data_out, held);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_count", sample_count, exp_count[15:0]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_count = (exp_count + 1) & 16'hFFFF;
    chk("out_valid_after_hs", out_valid, 0);
    chk("count_after_hs", sample_count, exp_count[15:0]);
    chk("in_ready_after_hs", in_ready, 1);
    chk("data_held_after_hs", data_out, held);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    exp_count = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    data_in   = 16'h0;
    shift_in  = 4'h0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_count", sample_count, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);

    run_sample(16'h1234, 4'd0, 0);
    run_sample(16'h8000, 4'd15, 0);
    run_sample(16'hC000, 4'd15, 0);
    run_sample(16'hFFFF, 4'd1, 0);
    run_sample(16'h0003, 4'd1, 0);
    run_sample(16'hABCD, 4'd4, 5);

    // Reset during the second SHIFT cycle of a 15-bit shift.
    @(negedge clk);
    data_in  = 16'hF0F0;
    shift_in = 4'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_data_out", data_out, 0);
    chk("midreset_count", sample_count, 0);
    chk("midreset_in_ready", in_ready, 0);
    exp_count = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("postreset_in_ready", in_ready, 1);
    run_sample(16'h4321, 4'd6, 0);

    for (int i = 0; i < 20; i++) begin
      run_sample(16'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end

    // Counter wrap via preload.
    @(negedge clk);
    force dut.r_sample_count = 16'hFFFE;
    #1;
    release dut.r_sample_count;
    exp_count = 16'hFFFE;
    run_sample(16'h7777, 4'd3, 0);
    run_sample(16'h0F0F, 4'd8, 1);
    chk("wrap_count_zero", sample_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
